// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment display driver.
// Segment vectors are active-low; bit order follows the seg_t field order.
package seg7_pkg;

  // MSB = a ... LSB = g
  typedef struct packed {
    logic a, b, c, d, e, f, g;
  } seg_t;

  localparam seg_t GLYPH_0   = 7'b0000001;
  localparam seg_t GLYPH_1   = 7'b1001111;
  localparam seg_t GLYPH_2   = 7'b0010010;
  localparam seg_t GLYPH_3   = 7'b0000110;
  localparam seg_t GLYPH_4   = 7'b1001100;
  localparam seg_t GLYPH_5   = 7'b0100100;
  localparam seg_t GLYPH_6   = 7'b0100000;
  localparam seg_t GLYPH_7   = 7'b0001111;
  localparam seg_t GLYPH_8   = 7'b0000000;
  localparam seg_t GLYPH_9   = 7'b0000100;
  localparam seg_t GLYPH_A   = 7'b0001000;
  localparam seg_t GLYPH_B   = 7'b1100000;
  localparam seg_t GLYPH_C   = 7'b0110001;
  localparam seg_t GLYPH_D   = 7'b1000010;
  localparam seg_t GLYPH_E   = 7'b0110000;
  localparam seg_t GLYPH_F   = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Load-side and display-side signals of the scan mux; the datapath drives
// the master side, the display driver implements the slave side.
interface seg7_scan_mux_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   an;
  seg_t                    seg;
  logic                    dp_n;
  logic [IDX_W-1:0]        digit_idx;

  modport master (output load, value, dp, blank,
                  input  an, seg, dp_n, digit_idx);
  modport slave  (input  load, value, dp, blank,
                  output an, seg, dp_n, digit_idx);
endinterface

// File: rtl/seg7_glyph_dec.sv
// Nibble to active-low 7-segment glyph. With hex_mode_i low, codes above 9
// decode to an all-off pattern.
module seg7_glyph_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       hex_mode_i,
  output seg_t       glyph_o
);
  always_comb begin
    glyph_o = SEG_BLANK;
    case (nib_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = hex_mode_i ? GLYPH_A : SEG_BLANK;
      4'hB: glyph_o = hex_mode_i ? GLYPH_B : SEG_BLANK;
      4'hC: glyph_o = hex_mode_i ? GLYPH_C : SEG_BLANK;
      4'hD: glyph_o = hex_mode_i ? GLYPH_D : SEG_BLANK;
      4'hE: glyph_o = hex_mode_i ? GLYPH_E : SEG_BLANK;
      default: glyph_o = hex_mode_i ? GLYPH_F : SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit common-anode 7-segment driver: shadow-latched
// value, cyclic digit scan, leading-zero blanking and anode dead-time.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV_CYCLES  = 100000,
  parameter int HEX_MODE    = 1,
  parameter int LZ_BLANK    = 0,
  parameter int DEAD_CYCLES = 1
)(
  input  logic           clk,
  input  logic           rst_n,
  seg7_scan_mux_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(DIV_CYCLES);

  logic [NUM_DIGITS-1:0][3:0] value_q;
  logic [NUM_DIGITS-1:0]      dp_q, blank_q;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  seg_t                       seg_q, seg_d, glyph;
  logic                       dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]      nz_from, lz_dark;
  logic [3:0]                 nib;
  logic                       slot_end, in_dead, dark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else if (bus.load) begin
      value_q <= bus.value;
      dp_q    <= bus.dp;
      blank_q <= bus.blank;
    end
  end

  // nz_from[i]: some nibble at position i or above is non-zero
  assign nz_from[NUM_DIGITS-1] = |value_q[NUM_DIGITS-1];
  for (genvar i = NUM_DIGITS - 2; i >= 0; i--) begin : g_nz
    assign nz_from[i] = (|value_q[i]) | nz_from[i+1];
  end
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    assign lz_dark[i] = (LZ_BLANK != 0) && (i != 0) && !nz_from[i];
  end

  assign nib = value_q[idx_q];

  seg7_glyph_dec u_dec (
    .nib_i      (nib),
    .hex_mode_i (HEX_MODE != 0),
    .glyph_o    (glyph)
  );

  always_comb begin
    slot_end = (div_q == DIV_W'(DIV_CYCLES - 1));
    in_dead  = (div_q < DIV_W'(DEAD_CYCLES));
    div_d    = slot_end ? '0 : div_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end)
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    dark = blank_q[idx_q] | lz_dark[idx_q] | ((HEX_MODE == 0) && (nib > 4'd9));
    // cathodes hold through the dead window; only the anodes go off
    an_d   = in_dead ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d  = in_dead ? seg_q : (dark ? SEG_BLANK : glyph);
    dp_n_d = in_dead ? dp_n_q : (dark | ~dp_q[idx_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
      dp_n_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp_n      = dp_n_q;
  assign bus.digit_idx = idx_q;

endmodule
